beeb_bus_sequencer: RTL
=======================

Name: beeb_bus_sequencer

Overview:
- Sequences every CPU access that must go out to the host BBC Micro bus.
- Synchronises the host Phi0 into the fast CPU clock domain and aligns each external cycle to a Phi0 falling edge.
- Drives the registered host address/data/RW, captures read data, and produces the CPU clock-enable.
- Also paces internal (Block RAM) cycles with a programmable divider, and enforces a post-write slowdown after addressable-latch writes at FE40.

Parameters:
- NPHI0_REGS, 5, depth of the Phi0 synchroniser/delay chain; must be at least PHIOUT_TAP+3.
- PHIOUT_TAP, 1, chain tap driving phi1_out/phi2_out.
- SLOW_LONG, 15, slowdown count after an FE40 write with data[2:0]==0.
- SLOW_SHORT, 1, slowdown count after any other FE40 write.

Ports:
- clk  in  1  CPU clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- phi_in  in  1  asynchronous host Phi0.
- phi1_out  out  1  equals !phi_r[PHIOUT_TAP].
- phi2_out  out  1  equals phi_r[PHIOUT_TAP].
- req  in  1  current CPU access is external; held until clken.
- int_ok  in  1  current CPU access is internal.
- req_addr  in  16  registered CPU address.
- req_we  in  1  registered CPU write strobe.
- req_dout  in  8  registered CPU write data.
- cpu_div  in  6  internal divider terminal count; 0 = every clk.
- clken  out  1  combinational, one-clk advance pulse to the CPU core.
- rd_data  out  8  captured host read data.
- bus_din  in  8  host data bus input.
- bus_addr  out  16  host address.
- bus_we  out  1  host write; R/W_n = !bus_we.
- bus_dout  out  8  host write data.
- bus_doe  out  1  equals bus_we & phi2_out.
- slow_active  out  1  slowdown counter is non-zero.

Behaviour:
- Phi chain: phi_r <= {phi_r[N-2:0], phi_in}.
  - cycle_end = phi_r[N-1] & !phi_r[N-2].
  - cycle_start = cycle_end registered by one clk.
  - sample = phi_r[PHIOUT_TAP+1] & !phi_r[PHIOUT_TAP].
- Reset values: phi_r=0, state=IDLE, bus_addr=FFFF, bus_we=0, bus_dout=FF, rd_data=00, div counter=0, slow counter=0, clken=0.
- States IDLE / BUSY, evaluated only on cycle_start:
  - If req & !int_ok: latch req_addr/req_we/req_dout onto the bus outputs, go to BUSY.
  - Otherwise: drive FFFF/0/FF, go to IDLE.
  - int_ok wins when req and int_ok are both high.
- Read capture: in BUSY, on sample, rd_data <= bus_din. This always precedes cycle_end.
- External completion: in BUSY, clken=1 during the cycle_end clk.
  - The state stays BUSY; the next clk is cycle_start, which re-evaluates the new request. Back-to-back external cycles therefore cost exactly one Phi0 period each.
- Divider: 6-bit counter; it goes to 0 when equal to cpu_div, otherwise increments.
  - If cpu_div is lowered below the counter, the counter free-runs to 63 and wraps to 0.
- Internal clken: state==IDLE & int_ok & counter==0 & slow==0.
- Slowdown (SLOWDOWN_EN), updated on cycle_end:
  - If BUSY & bus_addr==FE40 & bus_we: load SLOW_LONG if bus_dout[2:0]==0, else SLOW_SHORT.
  - Otherwise, if slow>0, decrement.
  - While non-zero, the CPU advances only via external-cycle clken.
- Reset asserted during BUSY abandons the cycle. No clken is issued, and the bus returns to its idle values on the next clk.

Optional Feature:
- BEEB_BUS_SLOWDOWN_EN defined: the FE40 slowdown counter is implemented as described.
- Undefined: no counter; slow_active is tied to 0; the internal clken ignores slowdown.

Decomposition:
- Package beeb_bus_pkg:
  - state enum {IDLE, BUSY};
  - ADDR_IDLE=16'hFFFF, DATA_IDLE=8'hFF, ADDR_SYSVIA_LATCH=16'hFE40;
  - SLOW_LONG/SLOW_SHORT defaults.
- Sub-module beeb_phi_sync: owns the delay chain and produces phi1/phi2_out, cycle_end, cycle_start and sample.

Test Plan:
- Reset, then 1 MHz-equivalent Phi0 with no req: bus_addr=FFFF, bus_we=0, bus_dout=FF throughout; clken never asserts with int_ok=0.
- int_ok=1, cpu_div=3: clken on every 4th clk; changing cpu_div 10->2 while the counter is at 7: counter wraps through 63->0, then pulses every 3rd clk.
- req read of FC00, bus_din=5A: bus_addr=FC00 from the clk after cycle_end, rd_data=5A on sample, exactly one clken on the next cycle_end, bus then returns to FFFF.
- Write FE40 data=08 then int_ok=1, cpu_div=0: bus_doe high only while phi2_out; slow=15; internal clken is suppressed for 15 further Phi0 cycles, then resumes every clk.
- Write FE40 data=0B: slow=1 for one Phi0 period. With the macro undefined: no suppression and slow_active stays 0.
- Assert reset two clks into BUSY: no clken, bus at FFFF/0/FF next clk, state IDLE; req and int_ok both high resolves as internal.

Source files
------------

// File: rtl/beeb_bus_pkg.sv
// ---------------------------------------------------------------------------
// beeb_bus_pkg
// Shared types and constants for the BBC Micro host bus sequencer.
//   bus_state_t        : IDLE (no external cycle) / BUSY (external cycle owns bus)
//   ADDR_IDLE          : address parked on the host bus between cycles
//   DATA_IDLE          : write data parked on the host bus between cycles
//   ADDR_SYSVIA_LATCH  : system VIA addressable latch, triggers CPU slowdown
//   SLOW_*_DEFAULT     : slowdown counts after a latch write
// ---------------------------------------------------------------------------
package beeb_bus_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } bus_state_t;

   localparam logic [15:0] ADDR_IDLE         = 16'hFFFF;
   localparam logic [7:0]  DATA_IDLE         = 8'hFF;
   localparam logic [15:0] ADDR_SYSVIA_LATCH = 16'hFE40;

   localparam int DIV_W              = 6;
   localparam int SLOW_W             = 4;
   localparam int SLOW_LONG_DEFAULT  = 15;
   localparam int SLOW_SHORT_DEFAULT = 1;

endpackage

// File: rtl/beeb_phi_sync.sv
// ---------------------------------------------------------------------------
// beeb_phi_sync
// Brings the asynchronous host Phi0 into the CPU clock domain through a
// shift chain and derives the timing strobes used by the bus sequencer.
// Ports:
//   clk          in   CPU clock
//   reset        in   synchronous active-high reset
//   phi_in       in   asynchronous host Phi0
//   phi1_out     out  inverted delayed Phi0 (chain tap)
//   phi2_out     out  delayed Phi0 (chain tap)
//   cycle_end    out  falling edge seen at the end of the chain
//   cycle_start  out  cycle_end delayed by one clk
//   sample       out  falling edge seen just after the output tap
// ---------------------------------------------------------------------------
module beeb_phi_sync #(
   parameter int NPHI0_REGS = 5,
   parameter int PHIOUT_TAP = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic phi_in,
   output logic phi1_out,
   output logic phi2_out,
   output logic cycle_end,
   output logic cycle_start,
   output logic sample
);

   logic [NPHI0_REGS-1:0] phi_r;

   // The first two stages act as the metastability synchroniser; the later
   // stages give a fixed delay so read data is sampled on the output-tap
   // falling edge, well before the sequencer ends the cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         phi_r       <= '0;
         cycle_start <= 1'b0;
      end else begin
         phi_r       <= {phi_r[NPHI0_REGS-2:0], phi_in};
         cycle_start <= cycle_end;
      end
   end

   assign cycle_end = phi_r[NPHI0_REGS-1] & ~phi_r[NPHI0_REGS-2];
   assign sample    = phi_r[PHIOUT_TAP+1] & ~phi_r[PHIOUT_TAP];
   assign phi2_out  = phi_r[PHIOUT_TAP];
   assign phi1_out  = ~phi_r[PHIOUT_TAP];

endmodule

// File: rtl/beeb_bus_sequencer.sv
// ---------------------------------------------------------------------------
// beeb_bus_sequencer
// Runs every CPU access that must appear on the host BBC Micro bus, aligned
// to host Phi0 falling edges, and paces internal (Block RAM) accesses with a
// programmable divider. The CPU core advances on each clken pulse.
// Optional feature macro: BEEB_BUS_SLOWDOWN_EN enables the post-write
// slowdown after writes to the system VIA addressable latch (FE40).
// Ports:
//   clk, reset            CPU clock, synchronous active-high reset
//   phi_in                asynchronous host Phi0
//   phi1_out, phi2_out    delayed host clock phases
//   req, int_ok           current access is external / internal
//   req_addr/we/dout      registered CPU address, write strobe, write data
//   cpu_div               internal divider terminal count (0 = every clk)
//   clken                 one-clk advance pulse to the CPU core
//   rd_data               captured host read data
//   bus_din               host data bus input
//   bus_addr/we/dout/doe  host address, write, write data, data output enable
//   slow_active           post-write slowdown in progress
// ---------------------------------------------------------------------------
module beeb_bus_sequencer
   import beeb_bus_pkg::*;
#(
   parameter int NPHI0_REGS = 5,
   parameter int PHIOUT_TAP = 1,
   parameter int SLOW_LONG  = SLOW_LONG_DEFAULT,
   parameter int SLOW_SHORT = SLOW_SHORT_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             phi_in,
   output logic             phi1_out,
   output logic             phi2_out,
   input  logic             req,
   input  logic             int_ok,
   input  logic [15:0]      req_addr,
   input  logic             req_we,
   input  logic [7:0]       req_dout,
   input  logic [DIV_W-1:0] cpu_div,
   output logic             clken,
   output logic [7:0]       rd_data,
   input  logic [7:0]       bus_din,
   output logic [15:0]      bus_addr,
   output logic             bus_we,
   output logic [7:0]       bus_dout,
   output logic             bus_doe,
   output logic             slow_active
);

   bus_state_t       state;
   bus_state_t       state_next;
   logic             load_ext;
   logic             cycle_end;
   logic             cycle_start;
   logic             sample;
   logic [DIV_W-1:0] div_cnt;

   beeb_phi_sync #(
      .NPHI0_REGS (NPHI0_REGS),
      .PHIOUT_TAP (PHIOUT_TAP)
   ) u_phi_sync (
      .clk         (clk),
      .reset       (reset),
      .phi_in      (phi_in),
      .phi1_out    (phi1_out),
      .phi2_out    (phi2_out),
      .cycle_end   (cycle_end),
      .cycle_start (cycle_start),
      .sample      (sample)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Decisions are only taken at a Phi0 cycle boundary. An internal access
   // takes priority so a stale req never steals a host cycle.
   always_comb begin
      state_next = state;
      load_ext   = 1'b0;
      if (cycle_start) begin
         if (req && !int_ok) begin
            state_next = BUSY;
            load_ext   = 1'b1;
         end else begin
            state_next = IDLE;
         end
      end
   end

   // The host bus is parked at FFFF/read/FF whenever no external cycle runs.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus_addr <= ADDR_IDLE;
         bus_we   <= 1'b0;
         bus_dout <= DATA_IDLE;
      end else if (cycle_start) begin
         if (load_ext) begin
            bus_addr <= req_addr;
            bus_we   <= req_we;
            bus_dout <= req_dout;
         end else begin
            bus_addr <= ADDR_IDLE;
            bus_we   <= 1'b0;
            bus_dout <= DATA_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= 8'h00;
      end else if (state == BUSY && sample) begin
         rd_data <= bus_din;
      end
   end

   // Lowering cpu_div below the running count lets the counter free-run
   // through its natural 6-bit wrap rather than forcing an early pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (div_cnt == cpu_div) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

`ifdef BEEB_BUS_SLOWDOWN_EN
   logic [SLOW_W-1:0] slow_cnt;

   // Writes to the addressable latch need the host to settle before the CPU
   // races ahead internally; the count is in Phi0 periods.
   always_ff @(posedge clk) begin
      if (reset) begin
         slow_cnt <= '0;
      end else if (cycle_end) begin
         if (state == BUSY && bus_addr == ADDR_SYSVIA_LATCH && bus_we) begin
            slow_cnt <= (bus_dout[2:0] == 3'b000) ? SLOW_W'(SLOW_LONG)
                                                  : SLOW_W'(SLOW_SHORT);
         end else if (slow_cnt != '0) begin
            slow_cnt <= slow_cnt - 1'b1;
         end
      end
   end

   assign slow_active = (slow_cnt != '0);
`else
   assign slow_active = 1'b0;
`endif

   // Reset gates clken so an abandoned external cycle never advances the CPU.
   always_comb begin
      clken = 1'b0;
      if (!reset) begin
         if (state == BUSY && cycle_end) begin
            clken = 1'b1;
         end else if (state == IDLE && int_ok && div_cnt == '0 && !slow_active) begin
            clken = 1'b1;
         end
      end
   end

   assign bus_doe = bus_we & phi2_out;

endmodule
